// File: rtl/microseq_pkg.sv
// Shared definitions for the microsequencer: next-address codes, field positions
// and condition-source indices.
package microseq_pkg;

    typedef enum logic [2:0] {
        NS_ENC  = 3'd0,
        NS_INC  = 3'd1,
        NS_JMP  = 3'd2,
        NS_CJMP = 3'd3,
        NS_CENC = 3'd4,
        NS_CALL = 3'd5,
        NS_RET  = 3'd6,
        NS_WAIT = 3'd7
    } nsel_e;

    localparam int unsigned N_W    = 3;
    localparam int unsigned S_W    = 2;
    localparam int unsigned COND_W = 4;

    localparam int unsigned COND_MOC  = 0;
    localparam int unsigned COND_EVAL = 1;
    localparam int unsigned COND_IR   = 2;
    localparam int unsigned COND_ZERO = 3;

    function automatic int unsigned n_msb(input int unsigned word_w);
        return word_w - 1;
    endfunction

    function automatic int unsigned inv_pos(input int unsigned word_w);
        return word_w - 4;
    endfunction

    function automatic int unsigned s_msb(input int unsigned word_w);
        return word_w - 5;
    endfunction

    function automatic int unsigned ctl_msb(input int unsigned word_w);
        return word_w - 7;
    endfunction

    function automatic int unsigned ctl_lsb(input int unsigned addr_w);
        return addr_w;
    endfunction

endpackage

// File: rtl/microstore_ram.sv
// Writable microstore: synchronous write port, combinational read port.
module microstore_ram #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WORD_W = 32
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/microsequencer.sv
// Microprogrammed control sequencer: microstore, control register, 8-way
// next-address selector with condition test and a return-address stack.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Encoder,
    input  logic [COND_W-1:0] Cond,
    input  logic              Stall,
    input  logic              ProgWe,
    input  logic [ADDR_W-1:0] ProgAddr,
    input  logic [WORD_W-1:0] ProgData,
    output logic [WORD_W-1:0] CtrlOut,
    output logic [ADDR_W-1:0] UPC,
    output logic              StackErr
);

    localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned N_MSB  = n_msb(WORD_W);
    localparam int unsigned INV_B  = inv_pos(WORD_W);
    localparam int unsigned S_MSB  = s_msb(WORD_W);
    localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);

    nsel_e             nsel;
    logic              inv;
    logic [S_W-1:0]    sel;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] upc_inc;
    logic [ADDR_W-1:0] next_upc;
    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] stack_top;
    logic [WORD_W-1:0] rd_data;
    logic              cond_c;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    microstore_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_store (
        .Clk     (Clk),
        .we      (ProgWe),
        .waddr   (ProgAddr),
        .wdata   (ProgData),
        .raddr   (fetch_addr),
        .rdata_c (rd_data)
    );

    assign nsel      = nsel_e'(CtrlOut[N_MSB -: N_W]);
    assign inv       = CtrlOut[INV_B];
    assign sel       = CtrlOut[S_MSB -: S_W];
    assign target    = CtrlOut[ADDR_W-1:0];
    assign cond_c    = Cond[sel] ^ inv;
    assign upc_inc   = UPC + ADDR_W'(1);
    assign empty     = (sp == '0);
    assign full      = (sp == SP_W'(STACK_DEPTH));
    assign stack_top = stack_mem[empty ? IDX_W'(0) : IDX_W'(sp - SP_W'(1))];

    // Next-address selection and stack requests.
    always_comb begin
        next_upc = upc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        case (nsel)
            NS_ENC:  next_upc = Encoder;
            NS_INC:  next_upc = upc_inc;
            NS_JMP:  next_upc = target;
            NS_CJMP: if (cond_c) next_upc = target;
            NS_CENC: if (cond_c) next_upc = Encoder;
            NS_CALL: begin
                next_upc = target;
                push     = 1'b1;
            end
            NS_RET: begin
                pop      = 1'b1;
                next_upc = empty ? RST_A : stack_top;
            end
            NS_WAIT: if (!cond_c) next_upc = UPC;
            default: next_upc = upc_inc;
        endcase
        fetch_addr = Reset ? RST_A : next_upc;
    end

    // Sequencer state: microaddress, control register, stack pointer, error flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            UPC      <= RST_A;
            CtrlOut  <= rd_data;
            sp       <= '0;
            StackErr <= 1'b0;
        end else if (!Stall) begin
            UPC     <= next_upc;
            CtrlOut <= rd_data;
            if (push) begin
                if (full) StackErr <= 1'b1;
                else      sp       <= sp + SP_W'(1);
            end
            if (pop) begin
                if (empty) StackErr <= 1'b1;
                else       sp       <= sp - SP_W'(1);
            end
        end
    end

    // Return-address storage; a push on a full stack is dropped.
    always_ff @(posedge Clk) begin
        if (!Reset && !Stall && push && !full) stack_mem[IDX_W'(sp)] <= upc_inc;
    end

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: directed microprograms, expected
// UPC/CtrlOut/StackErr queued per edge and compared by a monitor.
module tb_microsequencer;
    import microseq_pkg::*;

    localparam int unsigned AW = 6;
    localparam int unsigned WW = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] Encoder = '0;
    logic [3:0]    Cond = '0;
    logic          Stall = 1'b0;
    logic          ProgWe = 1'b0;
    logic [AW-1:0] ProgAddr = '0;
    logic [WW-1:0] ProgData = '0;
    logic [WW-1:0] CtrlOut;
    logic [AW-1:0] UPC;
    logic          StackErr;

    typedef struct packed {
        logic [AW-1:0] upc;
        logic [WW-1:0] ctrl;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [WW-1:0] img [64];
    logic          exp_err = 1'b0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 Clk = ~Clk;

    microsequencer #(
        .ADDR_W      (AW),
        .WORD_W      (WW),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Encoder  (Encoder),
        .Cond     (Cond),
        .Stall    (Stall),
        .ProgWe   (ProgWe),
        .ProgAddr (ProgAddr),
        .ProgData (ProgData),
        .CtrlOut  (CtrlOut),
        .UPC      (UPC),
        .StackErr (StackErr)
    );

    function automatic logic [WW-1:0] mk(input logic [2:0] n, input logic inv,
                                         input logic [1:0] s, input logic [AW-1:0] tgt,
                                         input logic [19:0] tag);
        return {n, inv, s, tag, tgt};
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("upc", WW'(UPC), WW'(mon_e.upc));
            chk("ctrl", CtrlOut, mon_e.ctrl);
            chk("stack_err", WW'(StackErr), WW'(mon_e.err));
        end
    end

    // One clock edge; expected CtrlOut is the image word as it stood before the edge.
    task automatic step(input logic [AW-1:0] eu);
        exp_t e;
        e.upc  = eu;
        e.ctrl = img[eu];
        e.err  = exp_err;
        @(posedge Clk);
        exp_q.push_back(e);
        #1;
        ProgWe = 1'b0;
    endtask

    task automatic wstep(input logic [AW-1:0] eu, input logic [AW-1:0] a, input logic [WW-1:0] w);
        ProgWe   = 1'b1;
        ProgAddr = a;
        ProgData = w;
        step(eu);
        img[a] = w;
    endtask

    task automatic prog(input logic [AW-1:0] a, input logic [WW-1:0] w);
        ProgWe   = 1'b1;
        ProgAddr = a;
        ProgData = w;
        @(posedge Clk);
        #1;
        ProgWe = 1'b0;
        img[a] = w;
    endtask

    task automatic do_reset();
        exp_err = 1'b0;
        Reset   = 1'b1;
        step(0);
        step(0);
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        // Increment then jump.
        Reset = 1'b1;
        prog(0, mk(NS_INC, 0, 0, 0, 20'h00001));
        prog(1, mk(NS_JMP, 0, 0, 5, 20'h00002));
        prog(5, mk(NS_JMP, 0, 0, 5, 20'h00003));
        do_reset();
        step(1); step(5); step(5);

        // Wait on MOC.
        Reset = 1'b1;
        prog(0, mk(NS_JMP, 0, 0, 3, 20'h00010));
        prog(3, mk(NS_WAIT, 0, 0, 0, 20'h00011));
        prog(4, mk(NS_JMP, 0, 0, 4, 20'h00012));
        do_reset();
        Cond = 4'b0000;
        step(3); step(3); step(3); step(3);
        Cond = 4'b0001;
        step(4);
        Cond = 4'b0000;

        // Calls, nesting, overflow and LIFO returns.
        Reset = 1'b1;
        prog(0,  mk(NS_JMP,  0, 0, 2,  20'h00020));
        prog(2,  mk(NS_CALL, 0, 0, 10, 20'h00021));
        prog(10, mk(NS_RET,  0, 0, 0,  20'h00022));
        prog(3,  mk(NS_CALL, 0, 0, 20, 20'h00023));
        prog(20, mk(NS_CALL, 0, 0, 30, 20'h00024));
        prog(30, mk(NS_CALL, 0, 0, 40, 20'h00025));
        prog(40, mk(NS_CALL, 0, 0, 50, 20'h00026));
        prog(50, mk(NS_CALL, 0, 0, 60, 20'h00027));
        prog(60, mk(NS_RET,  0, 0, 0,  20'h00028));
        prog(41, mk(NS_RET,  0, 0, 0,  20'h00029));
        prog(31, mk(NS_RET,  0, 0, 0,  20'h0002A));
        prog(21, mk(NS_RET,  0, 0, 0,  20'h0002B));
        prog(4,  mk(NS_RET,  0, 0, 0,  20'h0002C));
        do_reset();
        step(2); step(10); step(3);
        step(20); step(30); step(40); step(50);
        exp_err = 1'b1;
        step(60); step(41); step(31); step(21); step(4); step(0);

        // Empty-stack return, then stall with microstore writes underneath.
        Reset = 1'b1;
        prog(0, mk(NS_JMP, 0, 0, 7, 20'h00030));
        prog(7, mk(NS_RET, 0, 0, 0, 20'h00031));
        do_reset();
        step(7);
        exp_err = 1'b1;
        step(0); step(7);
        Stall = 1'b1;
        wstep(7, 0, mk(NS_JMP, 0, 0, 9, 20'h00040));
        wstep(7, 9, mk(NS_JMP, 0, 0, 9, 20'h00041));
        step(7);
        Stall = 1'b0;
        step(0); step(9); step(9);

        // Conditional encoder dispatch with inverted condition, then wrap.
        Reset = 1'b1;
        prog(0,  mk(NS_JMP,  0, 0,    8,  20'h00050));
        prog(8,  mk(NS_CENC, 1, 2'd1, 0,  20'h00051));
        prog(20, mk(NS_JMP,  0, 0,    8,  20'h00052));
        prog(9,  mk(NS_JMP,  0, 0,    63, 20'h00053));
        prog(63, mk(NS_INC,  0, 0,    0,  20'h00054));
        do_reset();
        Encoder = 6'd20;
        Cond    = 4'b0000;
        step(8); step(20); step(8);
        Cond = 4'b0010;
        step(9);
        Cond = 4'b0000;
        step(63); step(0);

        // Same-edge write/fetch, then reset in the middle of nested calls.
        Reset = 1'b1;
        prog(0,  mk(NS_JMP,  0, 0, 1,  20'h00060));
        prog(1,  mk(NS_JMP,  0, 0, 0,  20'h00061));
        prog(11, mk(NS_CALL, 0, 0, 12, 20'h00062));
        prog(12, mk(NS_JMP,  0, 0, 12, 20'h00063));
        do_reset();
        wstep(1, 1, mk(NS_CALL, 0, 0, 11, 20'h00064));
        step(0); step(1); step(11); step(12); step(12);
        Reset = 1'b1;
        exp_err = 1'b0;
        wstep(0, 0, mk(NS_RET, 0, 0, 0, 20'h00065));
        step(0);
        Reset   = 1'b0;
        exp_err = 1'b1;
        step(0);

        @(negedge Clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending entries required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
